// File: rtl/dmem_sbuf_if.sv
// Request/response bundle between the execute stage (master) and the dmem_sbuf
// data-memory responder (slave).
interface dmem_sbuf_if #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int SBUF_CNT_WIDTH  = 3
);
  logic                       in_act_load_dmem;
  logic                       in_act_store_dmem;
  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr;
  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr;
  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word;
  logic                       out_rd_valid;
  logic [DMEM_WORD_WIDTH-1:0] out_rd_word;
  logic                       out_stall;
  logic                       out_sbuf_empty;
  logic [SBUF_CNT_WIDTH-1:0]  out_sbuf_count;

  modport master (
    output in_act_load_dmem, in_act_store_dmem, in_dmem_rd_addr,
           in_dmem_wr_addr, in_dmem_wr_word,
    input  out_rd_valid, out_rd_word, out_stall, out_sbuf_empty, out_sbuf_count
  );

  modport slave (
    input  in_act_load_dmem, in_act_store_dmem, in_dmem_rd_addr,
           in_dmem_wr_addr, in_dmem_wr_word,
    output out_rd_valid, out_rd_word, out_stall, out_sbuf_empty, out_sbuf_count
  );
endinterface

// File: rtl/dmem_sbuf.sv
// Data memory with an in-order store buffer: stores retire into the buffer and
// drain on load-free cycles; loads forward from the youngest matching entry.
module dmem_sbuf #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int SBUF_DEPTH      = 4,
  parameter int SBUF_CNT_WIDTH  = 3
) (
  input  logic        clock,
  input  logic        reset,
  dmem_sbuf_if.slave  bus
);
  localparam int IDX_W = DMEM_ADDR_WIDTH - 1;
  localparam int PTR_W = $clog2(SBUF_DEPTH);
  localparam logic [SBUF_CNT_WIDTH-1:0] FULL_CNT = SBUF_CNT_WIDTH'(SBUF_DEPTH);

  logic [DMEM_WORD_WIDTH-1:0] r_mem     [2**IDX_W];
  logic [IDX_W-1:0]           r_sb_idx  [SBUF_DEPTH];
  logic [DMEM_WORD_WIDTH-1:0] r_sb_data [SBUF_DEPTH];

  logic [PTR_W-1:0]           r_head, r_tail;
  logic [SBUF_CNT_WIDTH-1:0]  r_count;
  logic                       r_empty;
  logic                       r_rd_valid;
  logic [DMEM_WORD_WIDTH-1:0] r_rd_word;

  logic [IDX_W-1:0]           w_rd_idx, w_wr_idx;
  logic                       w_stall, w_enq, w_drain, w_hit;
  logic [DMEM_WORD_WIDTH-1:0] w_fwd;
  logic [PTR_W-1:0]           w_pos;
  logic [SBUF_CNT_WIDTH-1:0]  w_count_nxt;
  logic                       w_unused_addr_lsb;

  assign w_rd_idx          = bus.in_dmem_rd_addr[DMEM_ADDR_WIDTH-1:1];
  assign w_wr_idx          = bus.in_dmem_wr_addr[DMEM_ADDR_WIDTH-1:1];
  assign w_unused_addr_lsb = bus.in_dmem_rd_addr[0] ^ bus.in_dmem_wr_addr[0];

  // A full buffer only blocks a store when a load also owns the array port.
  assign w_stall = bus.in_act_store_dmem & (r_count == FULL_CNT) & bus.in_act_load_dmem;
  assign w_enq   = bus.in_act_store_dmem & ~w_stall;
  assign w_drain = (r_count != '0) & ~bus.in_act_load_dmem;

  // Walk oldest to youngest so the last match is the youngest store.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    w_pos = r_head;
    for (int i = 0; i < SBUF_DEPTH; i++) begin
      w_pos = r_head + PTR_W'(i);
      if ((SBUF_CNT_WIDTH'(i) < r_count) && (r_sb_idx[w_pos] == w_rd_idx)) begin
        w_hit = 1'b1;
        w_fwd = r_sb_data[w_pos];
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_enq && !w_drain)      w_count_nxt = r_count + SBUF_CNT_WIDTH'(1);
    else if (!w_enq && w_drain) w_count_nxt = r_count - SBUF_CNT_WIDTH'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_word  <= '0;
    end else begin
      if (w_enq)   r_tail <= r_tail + PTR_W'(1);
      if (w_drain) r_head <= r_head + PTR_W'(1);
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_rd_valid <= bus.in_act_load_dmem;
      if (bus.in_act_load_dmem) r_rd_word <= w_hit ? w_fwd : r_mem[w_rd_idx];
      else                      r_rd_word <= '0;
    end
  end

  // Storage is never reset; discarded entries simply become unreachable.
  always_ff @(posedge clock) begin
    if (w_drain) r_mem[r_sb_idx[r_head]] <= r_sb_data[r_head];
    if (w_enq) begin
      r_sb_idx[r_tail]  <= w_wr_idx;
      r_sb_data[r_tail] <= bus.in_dmem_wr_word;
    end
  end

  assign bus.out_stall      = w_stall;
  assign bus.out_rd_valid   = r_rd_valid;
  assign bus.out_rd_word    = r_rd_word;
  assign bus.out_sbuf_empty = r_empty;
  assign bus.out_sbuf_count = r_count;
endmodule

// File: tb/tb_dmem_sbuf.sv
// Directed bench for dmem_sbuf: drain, forwarding, same-cycle hazards, full stall,
// pointer wrap and asynchronous reset.
module tb_dmem_sbuf;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  dmem_sbuf_if #(.DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .SBUF_CNT_WIDTH(3)) bus ();

  dmem_sbuf #(
    .DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .SBUF_DEPTH(4), .SBUF_CNT_WIDTH(3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input logic ld, input logic st, input logic [11:0] raddr,
                       input logic [11:0] waddr, input logic [15:0] wdata);
    bus.in_act_load_dmem  = ld;
    bus.in_act_store_dmem = st;
    bus.in_dmem_rd_addr   = raddr;
    bus.in_dmem_wr_addr   = waddr;
    bus.in_dmem_wr_word   = wdata;
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 12'h000, 12'h000, 16'h0000);
    reset = 1'b1;
    #3;
    checks++; if (bus.out_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.out_rd_valid); end
    checks++; if (bus.out_rd_word !== 16'h0000) begin errors++; $display("FAIL reset_rd_word: got %h expected 0000", bus.out_rd_word); end
    checks++; if (bus.out_sbuf_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.out_sbuf_empty); end
    checks++; if (bus.out_sbuf_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.out_sbuf_count); end
    checks++; if (bus.out_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.out_stall); end
    #10 reset = 1'b0;
    step();
  endtask

  task automatic test_drain;
    drive(1'b0, 1'b1, 12'h000, 12'h0A4, 16'hBEEF); step();
    checks++; if (bus.out_sbuf_count !== 3'd1) begin errors++; $display("FAIL drain_count_after_store: got %0d expected 1", bus.out_sbuf_count); end
    checks++; if (bus.out_sbuf_empty !== 1'b0) begin errors++; $display("FAIL drain_empty_after_store: got %b expected 0", bus.out_sbuf_empty); end
    drive(1'b0, 1'b0, 12'h000, 12'h000, 16'h0000); step();
    checks++; if (bus.out_sbuf_count !== 3'd0) begin errors++; $display("FAIL drain_count_after_idle: got %0d expected 0", bus.out_sbuf_count); end
    drive(1'b1, 1'b0, 12'h0A4, 12'h000, 16'h0000); step();
    checks++; if (bus.out_rd_valid !== 1'b1) begin errors++; $display("FAIL drain_rd_valid: got %b expected 1", bus.out_rd_valid); end
    checks++; if (bus.out_rd_word !== 16'hBEEF) begin errors++; $display("FAIL drain_rd_word: got %h expected beef", bus.out_rd_word); end
    drive(1'b0, 1'b0, 12'h000, 12'h000, 16'h0000); step();
    checks++; if (bus.out_rd_valid !== 1'b0) begin errors++; $display("FAIL drain_idle_valid: got %b expected 0", bus.out_rd_valid); end
    checks++; if (bus.out_rd_word !== 16'h0000) begin errors++; $display("FAIL drain_idle_word: got %h expected 0000", bus.out_rd_word); end
  endtask

  task automatic test_forward;
    drive(1'b0, 1'b1, 12'h000, 12'h010, 16'h1111); step();
    drive(1'b0, 1'b1, 12'h000, 12'h010, 16'h2222); step();
    drive(1'b1, 1'b0, 12'h011, 12'h000, 16'h0000); step();
    checks++; if (bus.out_rd_word !== 16'h2222) begin errors++; $display("FAIL fwd_youngest: got %h expected 2222", bus.out_rd_word); end
    drive(1'b0, 1'b0, 12'h000, 12'h000, 16'h0000); step(); step();
    drive(1'b1, 1'b0, 12'h010, 12'h000, 16'h0000); step();
    checks++; if (bus.out_rd_word !== 16'h2222) begin errors++; $display("FAIL fwd_after_drain: got %h expected 2222", bus.out_rd_word); end
  endtask

  task automatic test_same_cycle;
    drive(1'b0, 1'b1, 12'h000, 12'h020, 16'h5555); step();
    drive(1'b0, 1'b0, 12'h000, 12'h000, 16'h0000); step();
    drive(1'b1, 1'b1, 12'h020, 12'h020, 16'h7777); step();
    checks++; if (bus.out_rd_word !== 16'h5555) begin errors++; $display("FAIL same_cycle_old: got %h expected 5555", bus.out_rd_word); end
    checks++; if (bus.out_sbuf_count !== 3'd1) begin errors++; $display("FAIL same_cycle_count: got %0d expected 1", bus.out_sbuf_count); end
    drive(1'b0, 1'b0, 12'h000, 12'h000, 16'h0000); step();
    drive(1'b1, 1'b0, 12'h020, 12'h000, 16'h0000); step();
    checks++; if (bus.out_rd_word !== 16'h7777) begin errors++; $display("FAIL same_cycle_new: got %h expected 7777", bus.out_rd_word); end
  endtask

  task automatic test_full_stall;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 12'h0A4, 12'h050 + 12'(2 * i), 16'h1000 + 16'(i)); step();
    end
    checks++; if (bus.out_sbuf_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", bus.out_sbuf_count); end
    checks++; if (bus.out_rd_word !== 16'hBEEF) begin errors++; $display("FAIL full_load_word: got %h expected beef", bus.out_rd_word); end
    drive(1'b1, 1'b1, 12'h052, 12'h040, 16'h4444); #1;
    checks++; if (bus.out_stall !== 1'b1) begin errors++; $display("FAIL full_stall_high: got %b expected 1", bus.out_stall); end
    step();
    checks++; if (bus.out_sbuf_count !== 3'd4) begin errors++; $display("FAIL full_stall_count: got %0d expected 4", bus.out_sbuf_count); end
    checks++; if (bus.out_rd_word !== 16'h1001) begin errors++; $display("FAIL full_stall_fwd: got %h expected 1001", bus.out_rd_word); end
    drive(1'b0, 1'b1, 12'h000, 12'h040, 16'h4444); #1;
    checks++; if (bus.out_stall !== 1'b0) begin errors++; $display("FAIL full_stall_low: got %b expected 0", bus.out_stall); end
    step();
    checks++; if (bus.out_sbuf_count !== 3'd4) begin errors++; $display("FAIL full_enq_drain_count: got %0d expected 4", bus.out_sbuf_count); end
    drive(1'b0, 1'b0, 12'h000, 12'h000, 16'h0000);
    for (int i = 0; i < 4; i++) step();
    checks++; if (bus.out_sbuf_empty !== 1'b1) begin errors++; $display("FAIL full_drained_empty: got %b expected 1", bus.out_sbuf_empty); end
    drive(1'b1, 1'b0, 12'h040, 12'h000, 16'h0000); step();
    checks++; if (bus.out_rd_word !== 16'h4444) begin errors++; $display("FAIL full_retry_data: got %h expected 4444", bus.out_rd_word); end
    drive(1'b1, 1'b0, 12'h050, 12'h000, 16'h0000); step();
    checks++; if (bus.out_rd_word !== 16'h1000) begin errors++; $display("FAIL full_first_data: got %h expected 1000", bus.out_rd_word); end
    drive(1'b1, 1'b0, 12'h056, 12'h000, 16'h0000); step();
    checks++; if (bus.out_rd_word !== 16'h1003) begin errors++; $display("FAIL full_last_data: got %h expected 1003", bus.out_rd_word); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 12'h000, 12'h100 + 12'(2 * i), 16'hC000 + 16'(i)); step();
      drive(1'b0, 1'b0, 12'h000, 12'h000, 16'h0000); step();
    end
    checks++; if (bus.out_sbuf_count !== 3'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", bus.out_sbuf_count); end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 12'h100 + 12'(2 * i), 12'h000, 16'h0000); step();
      checks++;
      if (bus.out_rd_word !== 16'hC000 + 16'(i)) begin
        errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, bus.out_rd_word, 16'hC000 + 16'(i));
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 12'h000, 12'h200 + 12'(2 * i), 16'hAAAA + 16'(i * 16'h1111)); step();
      drive(1'b0, 1'b0, 12'h000, 12'h000, 16'h0000); step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 12'h0A4, 12'h200 + 12'(2 * i), 16'h0D00 + 16'(i)); step();
    end
    checks++; if (bus.out_sbuf_count !== 3'd3) begin errors++; $display("FAIL mid_pending_count: got %0d expected 3", bus.out_sbuf_count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.out_sbuf_count !== 3'd0) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", bus.out_sbuf_count); end
    checks++; if (bus.out_sbuf_empty !== 1'b1) begin errors++; $display("FAIL mid_reset_empty: got %b expected 1", bus.out_sbuf_empty); end
    checks++; if (bus.out_rd_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", bus.out_rd_valid); end
    drive(1'b0, 1'b0, 12'h000, 12'h000, 16'h0000);
    step();
    #2 reset = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 12'h200 + 12'(2 * i), 12'h000, 16'h0000); step();
      checks++;
      if (bus.out_rd_word !== 16'hAAAA + 16'(i * 16'h1111)) begin
        errors++; $display("FAIL mid_prior_data[%0d]: got %h expected %h", i, bus.out_rd_word, 16'hAAAA + 16'(i * 16'h1111));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_drain();
    test_forward();
    test_same_cycle();
    test_full_stall();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
